// File: rtl/ws2812_matrix_driver.sv
// WS2812 driver for an 8x8 matrix: walks pixels 0..63, fetches GRB from a colour source and
// serialises it with one-wire timing. Define WS2812_DIM_EN to right-shift channels by BRIGHT_SHIFT.
module ws2812_matrix_driver #(
   parameter int T0H_CYCLES   = 4,
   parameter int T1H_CYCLES   = 8,
   parameter int BIT_CYCLES   = 15,
   parameter int FETCH_CYCLES = 2,
   parameter int LATCH_CYCLES = 3600,
   parameter int BRIGHT_SHIFT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] red_data,
   input  logic [7:0] green_data,
   input  logic [7:0] blue_data,
   output logic [5:0] pixel,
   output logic [4:0] frame,
   output logic       dout,
   output logic       frame_done,
   output logic       busy
);

`ifdef WS2812_DIM_EN
   localparam bit DIM_EN = 1'b1;
`else
   localparam bit DIM_EN = 1'b0;
`endif
   localparam int SHIFT_AMT = DIM_EN ? BRIGHT_SHIFT : 0;

   localparam int CNT_MAX0 = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX0 > FETCH_CYCLES) ? CNT_MAX0 : FETCH_CYCLES;
   localparam int CW       = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
   localparam logic [CW-1:0] FETCH_LAST = CW'(FETCH_CYCLES - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
   localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);

   typedef enum logic [1:0] {ST_LATCH, ST_FETCH, ST_SHIFT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   shreg_q, shreg_d;
   logic [5:0]    pixel_q, pixel_d;
   logic [4:0]    frame_q, frame_d;
   logic          dout_q, dout_d;
   logic          frame_done_q, frame_done_d;
   logic          busy_q, busy_d;
   logic [CW-1:0] hi_len;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shreg_d      = shreg_q;
      pixel_d      = pixel_q;
      frame_d      = frame_q;
      dout_d       = 1'b0;
      frame_done_d = 1'b0;
      hi_len       = shreg_q[23] ? T1H : T0H;
      case (state_q)
         ST_LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               cnt_d   = '0;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_FETCH: begin
            if (cnt_q == FETCH_LAST) begin
               shreg_d = {green_data >> SHIFT_AMT, red_data >> SHIFT_AMT, blue_data >> SHIFT_AMT};
               bit_d   = 5'd23;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_SHIFT: begin
            // dout is one cycle behind cnt, so the high phase covers cnt 0..hi_len-1 delayed by one
            dout_d = (cnt_q < hi_len);
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (bit_q == 5'd0) begin
                  if (pixel_q == 6'd63) begin
                     pixel_d      = 6'd0;
                     frame_d      = frame_q + 5'd1;
                     frame_done_d = 1'b1;
                     state_d      = ST_LATCH;
                  end else begin
                     pixel_d = pixel_q + 6'd1;
                     state_d = ST_FETCH;
                  end
               end else begin
                  bit_d   = bit_q - 5'd1;
                  shreg_d = {shreg_q[22:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_LATCH;
         end
      endcase
      busy_d = (state_d != ST_LATCH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_LATCH;
         cnt_q        <= '0;
         bit_q        <= '0;
         shreg_q      <= '0;
         pixel_q      <= '0;
         frame_q      <= '0;
         dout_q       <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shreg_q      <= shreg_d;
         pixel_q      <= pixel_d;
         frame_q      <= frame_d;
         dout_q       <= dout_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign pixel      = pixel_q;
   assign frame      = frame_q;
   assign dout       = dout_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_ws2812_matrix_driver.sv
// Scoreboard bench for ws2812_matrix_driver: a pixel-indexed colour table feeds the DUT, the
// expected GRB words are queued per refresh and a monitor decodes dout and compares.
module tb_ws2812_matrix_driver;
   localparam int T0H = 4, T1H = 8, BITC = 15, LATCH = 3600, REFRESH = 26768, DIM_SHIFT = 1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] red_data, green_data, blue_data;
   logic [5:0] pixel;
   logic [4:0] frame;
   logic       dout, frame_done, busy;

   ws2812_matrix_driver #(.BRIGHT_SHIFT(DIM_SHIFT)) dut (
      .clk(clk), .rst_n(rst_n), .red_data(red_data), .green_data(green_data),
      .blue_data(blue_data), .pixel(pixel), .frame(frame), .dout(dout),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 clk = ~clk;

   logic [7:0] rtab [64];
   logic [7:0] gtab [64];
   logic [7:0] btab [64];
   assign red_data   = rtab[pixel];
   assign green_data = gtab[pixel];
   assign blue_data  = btab[pixel];

   typedef struct packed {
      logic [5:0]  pix;
      logic [4:0]  frm;
      logic [23:0] grb;
   } exp_t;
   exp_t sb[$];

   int checks = 0, errors = 0, npop = 0, n = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] dim(input logic [7:0] v);
`ifdef WS2812_DIM_EN
      return v >> DIM_SHIFT;
`else
      return v;
`endif
   endfunction

   task automatic push_frame(input int f);
      for (int p = 0; p < 64; p++) begin
         exp_t e;
         e.pix = 6'(p);
         e.frm = 5'(f);
         e.grb = {dim(gtab[p]), dim(rtab[p]), dim(btab[p])};
         sb.push_back(e);
      end
   endtask

   task automatic fill_const(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      for (int p = 0; p < 64; p++) begin
         rtab[p] = r; gtab[p] = g; btab[p] = b;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   // After reset release: quiet latch, busy at cycle LATCH, first dout rise 3 cycles later.
   task automatic latch_check(input string tag);
      int viol, busy_n, dout_n;
      viol = 0; busy_n = -1; dout_n = -1; n = 0;
      for (int i = 0; i < LATCH + 50; i++) begin
         step();
         if (busy && busy_n < 0) busy_n = n;
         if (dout) begin
            dout_n = n;
            break;
         end
         if (n < LATCH && (busy || pixel != 0 || frame != 0)) viol++;
      end
      chk({tag, "_latch_quiet"}, viol, 0);
      chk({tag, "_busy_rise"}, busy_n, LATCH);
      chk({tag, "_dout_rise"}, dout_n, LATCH + 3);
   endtask

   task automatic wait_fd(output int at);
      at = -1;
      for (int i = 0; i < REFRESH + 100; i++) begin
         step();
         if (frame_done) begin
            at = n;
            break;
         end
      end
   endtask

   // Monitor: decodes the one-wire stream into words and checks them against the queue.
   initial begin
      int hi, lo, nb;
      logic prev;
      logic [23:0] word;
      logic [5:0] cpix;
      logic [4:0] cfrm;
      exp_t e;
      hi = 0; lo = 0; nb = 0; prev = 1'b0; word = '0; cpix = '0; cfrm = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!busy) begin
            hi = 0; lo = 0; nb = 0; prev = 1'b0;
         end else begin
            if (dout) begin
               if (!prev) begin
                  if (nb > 0) chk("bit_period", hi + lo, BITC);
                  else begin
                     cpix = pixel;
                     cfrm = frame;
                  end
                  hi = 1; lo = 0;
               end else hi++;
            end else if (prev) begin
               checks++;
               if (hi != T0H && hi != T1H) begin
                  errors++;
                  $display("FAIL pulse_width: got %0d want %0d or %0d", hi, T0H, T1H);
               end
               word = {word[22:0], (hi >= 6)};
               nb++;
               lo = 1;
               if (nb == 24) begin
                  nb = 0;
                  npop++;
                  if (sb.size() == 0) chk("sb_empty", 1, 0);
                  else begin
                     e = sb.pop_front();
                     chk("grb_word", word, e.grb);
                     chk("word_pixel", cpix, e.pix);
                     chk("word_frame", cfrm, e.frm);
                  end
               end
            end else lo++;
            prev = dout;
         end
      end
   end

   initial begin
      int fd1, fd2, seen, p0;
      rst_n = 1'b0;
      fill_const(8'h00, 8'hFF, 8'h00);
      repeat (5) @(posedge clk);
      #1;
      chk("rst_dout", dout, 0);
      chk("rst_pixel", pixel, 0);
      chk("rst_frame", frame, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      push_frame(0);
      rst_n = 1'b1;
      latch_check("init");

      seen = -1;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (pixel == 6'd1) begin
            seen = n;
            break;
         end
      end
      chk("pixel_step", seen, LATCH + 362);

      wait_fd(fd1);
      chk("fd1_cycle", fd1, REFRESH);
      chk("fd1_frame", frame, 1);
      chk("fd1_pixel", pixel, 0);
      chk("fd1_busy", busy, 0);
      fill_const(8'hA5, 8'h3C, 8'h81);
      push_frame(1);
      step();
      chk("fd_one_cycle", frame_done, 0);

      wait_fd(fd2);
      chk("fd_interval", fd2 - fd1, REFRESH);
      chk("fd2_frame", frame, 2);
      for (int p = 0; p < 64; p++) begin
         rtab[p] = 8'($urandom); gtab[p] = 8'($urandom); btab[p] = 8'($urandom);
      end
      rtab[0] = 8'hFF; gtab[0] = 8'hFF; btab[0] = 8'hFF;
      push_frame(2);

      seen = 0;
      for (int i = 0; i < 12000; i++) begin
         step();
         if (pixel == 6'd17 && dout) begin
            seen = 1;
            break;
         end
      end
      chk("reach_px17_high", seen, 1);
      rst_n = 1'b0;
      sb.delete();
      push_frame(0);
      step();
      chk("midrst_dout", dout, 0);
      chk("midrst_pixel", pixel, 0);
      chk("midrst_frame", frame, 0);
      chk("midrst_busy", busy, 0);
      rst_n = 1'b1;
      p0 = npop;
      latch_check("midrst");

      for (int i = 0; i < 1000 && npop == p0; i++) step();
      chk("post_rst_pixel0_seen", npop - p0, 1);
      chk("sb_remaining", sb.size(), 63);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
